// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction field
// positions, PC step and the branch-offset helper.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } fetch_state_e;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Word-scaled, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr > jump/jal > taken branch > sequential.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0]                  pc_i,
    input  logic [TARGET_MSB:TARGET_LSB] target_i,
    input  logic                         jr_i,
    input  logic                         jump_i,
    input  logic                         branch_i,
    input  logic                         nequal_i,
    input  logic                         zero_i,
    input  logic [31:0]                  rs_data_i,
    output logic [31:0]                  pc_plus4_o,
    output logic [31:0]                  next_pc_o
);

    logic [31:0] pc_plus4;
    logic [31:0] jr_target;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        branch_taken;

    // All additions wrap naturally at 32 bits.
    assign pc_plus4      = pc_i + PC_STEP;
    assign jr_target     = rs_data_i & ~32'h0000_0003;
    assign jump_target   = {pc_plus4[31:28], target_i, 2'b00};
    assign branch_target = pc_plus4 + branch_offset(target_i[IMM_MSB:IMM_LSB]);
    assign branch_taken  = branch_i & (zero_i ^ nequal_i);

    always_comb begin
        next_pc_o = pc_plus4;
        if (jr_i) begin
            next_pc_o = jr_target;
        end else if (jump_i) begin
            next_pc_o = jump_target;
        end else if (branch_taken) begin
            next_pc_o = branch_target;
        end
    end

    assign pc_plus4_o = pc_plus4;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch FSM (IDLE/FETCH/EXEC) with fetch timeout and retry.
// Define FETCH_PERF_EN to build the saturating stall-cycle counter on perf_stall.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic        jump,
    input  logic        branch,
    input  logic        nequal,
    input  logic        jal,
    input  logic        jr,
    input  logic        zero,
    input  logic [31:0] rs_data,
    input  logic        stall_in,
    output logic [31:0] perf_stall
);

    localparam logic [4:0] WAIT_LAST = 5'(IM_TIMEOUT - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [4:0]   wait_q, wait_d;
    logic [31:0]  next_pc;
    logic [31:0]  pc_plus4;

    next_pc_calc u_next_pc_calc (
        .pc_i       (pc_q),
        .target_i   (instr_q[TARGET_MSB:TARGET_LSB]),
        .jr_i       (jr),
        .jump_i     (jump | jal),
        .branch_i   (branch),
        .nequal_i   (nequal),
        .zero_i     (zero),
        .rs_data_i  (rs_data),
        .pc_plus4_o (pc_plus4),
        .next_pc_o  (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                wait_d  = '0;
            end
            ST_FETCH: begin
                if (im_ready) begin
                    instr_d = im_rdata;
                    wait_d  = '0;
                    state_d = ST_EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    // Timeout: pass through IDLE so im_req drops for one cycle.
                    wait_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 5'd1;
                end
            end
            ST_EXEC: begin
                if (!stall_in) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign im_req      = (state_q == ST_FETCH);
    assign im_addr     = pc_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign link_addr   = pc_plus4;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic        stall_cycle;

    always_comb begin
        stall_cycle = ((state_q == ST_FETCH) && !im_ready) ||
                      ((state_q == ST_EXEC) && stall_in);
        perf_d = perf_q;
        if (stall_cycle && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall = perf_q;
`else
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, branches, jal/jr,
// stall, fetch timeout, PC wrap and reset during fetch/exec.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        jump, branch, nequal, jal, jr, zero;
    logic [31:0] rs_data;
    logic        stall_in;
    logic [31:0] perf_stall;

    int checks   = 0;
    int failures = 0;
    logic [31:0] perf_base;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ready   (im_ready),
        .im_rdata   (im_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .link_addr  (link_addr),
        .jump       (jump),
        .branch     (branch),
        .nequal     (nequal),
        .jal        (jal),
        .jr         (jr),
        .zero       (zero),
        .rs_data    (rs_data),
        .stall_in   (stall_in),
        .perf_stall (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered in the first FETCH cycle: wait one cycle, then answer with word.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] word);
        chk({tag, "_req"}, {31'd0, im_req}, 32'd1);
        chk({tag, "_addr"}, im_addr, addr);
        tick();
        chk({tag, "_addr_hold"}, im_addr, addr);
        im_ready = 1'b1;
        im_rdata = word;
        tick();
        im_ready = 1'b0;
        im_rdata = 32'hBAD0_BAD0;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, word);
        chk({tag, "_pc"}, pc, addr);
        $display("fetch %s addr=%h word=%h", tag, addr, word);
    endtask

    // One EXEC cycle with the given controls; expect the next fetch address.
    task automatic do_exec(input string tag, input logic j_jr, input logic j_jump,
                           input logic j_br, input logic j_ne, input logic j_jal,
                           input logic j_zero, input logic [31:0] rs,
                           input logic [31:0] exp_next);
        jr = j_jr; jump = j_jump; branch = j_br; nequal = j_ne; jal = j_jal;
        zero = j_zero; rs_data = rs;
        tick();
        jr = 0; jump = 0; branch = 0; nequal = 0; jal = 0; zero = 0;
        rs_data = 32'h0;
        chk({tag, "_pulse"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_next"}, im_addr, exp_next);
        $display("exec %s next_addr=%h", tag, im_addr);
    endtask

    initial begin
        rst_n = 0; im_ready = 0; im_rdata = 0; jump = 0; branch = 0; nequal = 0;
        jal = 0; jr = 0; zero = 0; rs_data = 0; stall_in = 0;
        tick();
        tick();
        chk("rst_req", {31'd0, im_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_perf", perf_stall, 32'h0);
        rst_n = 1;
        chk("idle_req", {31'd0, im_req}, 32'd0);
        tick();

        // Sequential fetch 0,4,8
        do_fetch("seq0", 32'h0, 32'h0000_0020);
        do_exec("seq0", 0, 0, 0, 0, 0, 0, 0, 32'h4);
        do_fetch("seq1", 32'h4, 32'h0000_0021);
        do_exec("seq1", 0, 0, 0, 0, 0, 0, 0, 32'h8);
        do_fetch("seq2", 32'h8, 32'h0000_0022);
        do_exec("seq2", 0, 0, 0, 0, 0, 0, 0, 32'hC);
        do_fetch("seq3", 32'hC, 32'h0000_0023);
        do_exec("seq3", 0, 0, 0, 0, 0, 0, 0, 32'h10);

        // beq taken backwards: 0x14 - 16 = 0x04
        do_fetch("beq", 32'h10, 32'h1022_FFFC);
        do_exec("beq", 0, 0, 1, 0, 0, 1, 0, 32'h04);
        // j back to 0x10
        do_fetch("j10", 32'h04, 32'h0800_0004);
        do_exec("j10", 0, 1, 0, 0, 0, 0, 0, 32'h10);
        // bne with zero=1: not taken
        do_fetch("bne", 32'h10, 32'h1022_FFFC);
        do_exec("bne", 0, 0, 1, 1, 0, 1, 0, 32'h14);
        do_fetch("j40", 32'h14, 32'h0800_0010);
        do_exec("j40", 0, 1, 0, 0, 0, 0, 0, 32'h40);

        // jal then jr (jr wins over jump and taken branch; low bits cleared)
        do_fetch("jal", 32'h40, 32'h0C00_0100);
        chk("jal_link", link_addr, 32'h44);
        do_exec("jal", 0, 1, 0, 0, 1, 0, 0, 32'h400);
        do_fetch("jr", 32'h400, 32'h03E0_0008);
        do_exec("jr", 1, 1, 1, 0, 0, 1, 32'h47, 32'h44);

        // Stall for three EXEC cycles
        do_fetch("stall", 32'h44, 32'hA5A5_0001);
        perf_base = perf_stall;
        stall_in = 1;
        jump = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", pc, 32'h44);
            chk("stall_instr", instr, 32'hA5A5_0001);
        end
`ifdef FETCH_PERF_EN
        chk("stall_perf", perf_stall - perf_base, 32'd3);
`else
        chk("stall_perf", perf_stall, 32'd0);
`endif
        stall_in = 0;
        jump = 0;
        tick();
        chk("stall_next", im_addr, 32'h48);
        $display("stall held 3 cycles at pc=%h", pc);

        // Timeout: im_req high for 16 cycles, low on cycle 17, then retry
        for (int i = 1; i <= 16; i++) begin
            chk("tmo_req", {31'd0, im_req}, 32'd1);
            chk("tmo_addr", im_addr, 32'h48);
            tick();
        end
        chk("tmo_drop", {31'd0, im_req}, 32'd0);
        im_ready = 1;
        im_rdata = 32'hDEAD_BEEF;
        tick();
        im_ready = 0;
        chk("tmo_retry_req", {31'd0, im_req}, 32'd1);
        chk("tmo_retry_addr", im_addr, 32'h48);
        chk("tmo_ignore_ready", instr, 32'hA5A5_0001);
        $display("timeout retry addr=%h", im_addr);
        do_fetch("retry", 32'h48, 32'h0000_0030);
        do_exec("jrwrap", 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);

        // Wrap
        do_fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0031);
        chk("wrap_link", link_addr, 32'h0);
        do_exec("wrap", 0, 0, 0, 0, 0, 0, 0, 32'h0);
        do_fetch("z0", 32'h0, 32'h0000_0032);
        do_exec("z0", 0, 0, 0, 0, 0, 0, 0, 32'h4);

        // Reset mid-FETCH, late im_ready ignored
        tick();
        rst_n = 0;
        tick();
        chk("rstf_req", {31'd0, im_req}, 32'd0);
        chk("rstf_pc", pc, 32'h0);
        chk("rstf_instr", instr, 32'h0);
        chk("rstf_perf", perf_stall, 32'h0);
        rst_n = 1;
        im_ready = 1;
        im_rdata = 32'h1234_5678;
        chk("rstf_idle", {31'd0, im_req}, 32'd0);
        tick();
        im_ready = 0;
        chk("rstf_fetch_req", {31'd0, im_req}, 32'd1);
        chk("rstf_fetch_addr", im_addr, 32'h0);
        chk("rstf_late_ready", instr, 32'h0);
        $display("reset mid-fetch restarted at %h", im_addr);

        // Reset mid-EXEC
        do_fetch("rste", 32'h0, 32'h0000_0040);
        rst_n = 0;
        tick();
        chk("rste_valid", {31'd0, instr_valid}, 32'd0);
        chk("rste_req", {31'd0, im_req}, 32'd0);
        chk("rste_instr", instr, 32'h0);
        rst_n = 1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter IM_TIMEOUT, default 16, meaning the maximum wait cycles on im_ready before the fetch is retried.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- im_req  out  1  instruction-memory request.
- im_addr  out  32  instruction address.
- im_ready  in  1  instruction memory has returned im_rdata.
- im_rdata  in  32  instruction word.
- instr  out  32  latched instruction; opcode is [31:26], funct is [5:0].
- instr_valid  out  1  instr is being executed this cycle.
- pc  out  32  address of instr.
- link_addr  out  32  pc+4, the write data for jal.
- jump, branch, nequal, jal, jr  in  1 each  decoder controls for instr.
- zero  in  1  ALU zero flag.
- rs_data  in  32  register rs value, used as the jr target.
- stall_in  in  1  downstream (data memory) is not ready to commit.
- perf_stall  out  32  stall-cycle counter (see REQ-019).

Function
REQ-004 SHALL implement the states IDLE, FETCH and EXEC.
REQ-005 SHALL move IDLE->FETCH unconditionally one cycle after reset is released.
REQ-006 SHALL, in FETCH, drive im_req=1 and im_addr=pc, and hold both stable until im_ready.
REQ-007 SHALL, in FETCH with im_ready=1, capture im_rdata into instr and go to EXEC on the next edge; fetch latency is at least 2 cycles.
REQ-008 SHALL, after IM_TIMEOUT consecutive FETCH cycles without im_ready, drop im_req for one cycle and then re-request the same pc; the wait counter is 5 bits wide.
REQ-009 SHALL, in EXEC, drive instr_valid=1 and im_req=0.
REQ-010 SHALL stay in EXEC with instr, pc and instr_valid held while stall_in=1.
REQ-011 SHALL, in EXEC with stall_in=0, load next_pc into pc and go to FETCH.
REQ-012 SHALL compute next_pc with priority jr > jump > taken branch > sequential:
- jr: {rs_data[31:2],2'b00}; the low bits of a misaligned target are cleared.
- jump (including jal): {pc_plus4[31:28],instr[25:0],2'b00}.
- branch & (zero ^ nequal): pc_plus4 + (sign-extended instr[15:0] << 2).
- otherwise: pc_plus4.
REQ-013 SHALL perform all PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-014 SHALL drive link_addr = pc+4 combinationally, valid during EXEC.
REQ-015 SHALL ignore im_ready outside FETCH.
REQ-016 SHALL ignore the control inputs, zero and rs_data outside EXEC.

Reset
REQ-017 SHALL, on a rising edge with rst_n=0, set state=IDLE, pc=RESET_PC, instr=0, wait counter=0 and perf_stall=0.
REQ-018 SHALL, when reset is asserted mid-FETCH or mid-EXEC, drop im_req and instr_valid at that same edge and abandon the pending fetch; a late im_ready is then ignored.

Configuration
REQ-019 SHALL, with FETCH_PERF_EN defined, count in perf_stall every cycle with (FETCH & ~im_ready) or (EXEC & stall_in), saturating at 32'hFFFF_FFFF.
REQ-020 SHALL, without FETCH_PERF_EN defined, tie perf_stall to 0 and omit the counter logic.

Structure
REQ-021 SHALL take from the shared package mips_pkg:
- the state enum;
- the instruction field positions (opcode, funct, imm, target);
- PC_STEP=4.
REQ-022 SHALL place next-PC selection in one combinational sub-module, next_pc_calc; the FSM, registers and counters stay in pc_fetch_unit.

Verification
REQ-023 Bench SHALL cover sequential fetch: RESET_PC=0, im_ready one cycle after each im_req -> im_addr steps 0,4,8; one instr_valid pulse per instruction.
REQ-024 Bench SHALL cover a taken beq: pc=0x10, instr imm=16'hFFFC, branch=1, zero=1, nequal=0 -> next im_addr=0x04. The same case with nequal=1 -> 0x14.
REQ-025 Bench SHALL cover jal followed by jr:
- jal at pc=0x40, target=26'h0000100 -> im_addr=0x400, link_addr=0x44;
- then jr with rs_data=0x47 -> im_addr=0x44.
REQ-026 Bench SHALL cover stall and timeout:
- stall_in high for 3 EXEC cycles -> instr and pc held; with FETCH_PERF_EN, perf_stall increments by 3;
- im_ready never asserted -> im_req drops on cycle 17, then the same address is re-requested.
REQ-027 Bench SHALL cover wrap and reset:
- pc=0xFFFF_FFFC sequential -> next 0x0;
- rst_n low mid-FETCH -> im_req=0 at that edge, pc=RESET_PC, then IDLE->FETCH.
